// File: rtl/cla_mp_add_seq.sv
// Multi-precision add sequencer: one 16-bit carry-lookahead adder reused over LIMBS limbs,
// LSB limb first, carry chained through a register. Define CLA_MP_SEQ_SUB_EN to add a subtract mode.
module cla_mp_add_seq #(
  parameter int LIMBS = 4,
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [16*LIMBS-1:0]   a,
  input  logic [16*LIMBS-1:0]   b,
  input  logic                  cin,
`ifdef CLA_MP_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [16*LIMBS-1:0]   sum,
  output logic                  cout,
  output logic [1:0]            dbg_state
);
  localparam int W = 16 * LIMBS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is sampled only while IDLE; busy is high in RUN and DONE and any start
  // seen then is dropped. done is a one-cycle strobe that rises with the new sum/cout.
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             cout_q, cout_d, done_q, done_d;
`ifdef CLA_MP_SEQ_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic [15:0] lim_a, lim_b, add_b, add_sum;
  logic        add_cout;

  always_comb begin
    lim_a = '0;
    lim_b = '0;
    for (int i = 0; i < LIMBS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        lim_a = a_q[16*i +: 16];
        lim_b = b_q[16*i +: 16];
      end
    end
`ifdef CLA_MP_SEQ_SUB_EN
    add_b = sub_q ? ~lim_b : lim_b;
`else
    add_b = lim_b;
`endif
  end

  CLA_16bits u_cla (
    .a    (lim_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef CLA_MP_SEQ_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          state_d = S_RUN;
`ifdef CLA_MP_SEQ_SUB_EN
          sub_d   = sub;
          carry_d = sub ? 1'b1 : cin;
`else
          carry_d = cin;
`endif
        end
      end
      S_RUN: begin
        for (int i = 0; i < LIMBS; i++) begin
          if (idx_q == IDX_W'(i)) res_d[16*i +: 16] = add_sum;
        end
        carry_d = add_cout;
        if (idx_q == IDX_W'(LIMBS - 1)) state_d = S_DONE;
        else                            idx_d   = idx_q + 1'b1;
      end
      S_DONE: begin
        sum_d   = res_q;
        cout_d  = carry_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CLA_MP_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef CLA_MP_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule

// 16-bit two-level carry-lookahead adder: four 4-bit groups with group P/G feeding
// a lookahead unit; only the top carry leaves the block.
module CLA_16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] p, g, c;
  logic [3:0]  gp, gg;
  logic [4:0]  cg;

  always_comb begin
    p = a ^ b;
    g = a & b;
    for (int j = 0; j < 4; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    cg[0] = cin;
    cg[1] = gg[0] | (gp[0] & cin);
    cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = cg[j];
      c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
    end
    sum  = p ^ c;
    cout = cg[4];
  end

endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Bench for cla_mp_add_seq (LIMBS=4): scoreboard of {cout,sum}, latency/busy timing,
// start blocking, mid-operation reset and operand-capture checks.
module tb_cla_mp_add_seq;
  localparam int LIMBS = 4;
  localparam int W     = 16 * LIMBS;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic [1:0]   dbg_state;

  logic [W:0]   exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  cla_mp_add_seq #(.LIMBS(LIMBS), .IDX_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_MP_SEQ_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mcin, input logic msub);
    if (msub) return {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
    return {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (done) begin
      check("q_nonempty", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) check("result", {cout, sum}, exp_q.pop_front());
    end
  end

  // driver: one operation, returns done cycle (relative to the accepting edge) and busy count
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic tsub, input logic chg, output int done_cyc, output int busy_cnt);
    done_cyc = -1;
    busy_cnt = 0;
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    exp_q.push_back(model(ta, tb_v, tcin, tsub));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (chg) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      cin = ~cin;
`ifdef CLA_MP_SEQ_SUB_EN
      sub = ~sub;
`endif
    end
    check("run_state", dbg_state, 2'd1);
    if (busy) busy_cnt++;
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    check("done_seen", (done_cyc >= 0), 1'b1);
  endtask

  initial begin
    int dc, bc, n_done, d1, d2;
    logic [W-1:0] ra, rb;
    logic         rc;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", {cout, sum}, '0);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, dc, bc);
    check("t1_done_cyc", dc, 5);
    check("t1_busy_cnt", bc, 5);
    check("t1_idle_busy", busy, 1'b0);

    run_op({W{1'b1}}, '0, 1'b1, 1'b0, 1'b0, dc, bc);
    check("ripple_done_cyc", dc, 5);
    run_op({W{1'b1}}, {W{1'b1}}, 1'b1, 1'b0, 1'b0, dc, bc);
    run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 1'b0, dc, bc);

    // start held high: accepted once, then again only once idle
    @(negedge clk);
    a = 64'd3; b = 64'd4; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back(model(64'd3, 64'd4, 1'b0, 1'b0));
    exp_q.push_back(model(64'd3, 64'd4, 1'b0, 1'b0));
    n_done = 0; d1 = -1; d2 = -1;
    @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 9) start = 1'b0;
      if (done) begin
        n_done++;
        if (d1 < 0) d1 = c; else d2 = c;
      end
    end
    check("blk_n_done", n_done, 2);
    check("blk_first", d1, 5);
    check("blk_second", d2, 11);

    // reset while limb index 2 is in progress
    @(negedge clk);
    a = {W{1'b1}}; b = 64'h1; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_pre_state", dbg_state, 2'd1);
    rst_n = 1'b0;
    #1;
    check("abort_sum", {cout, sum}, '0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0, dc, bc);
    check("post_rst_done_cyc", dc, 5);

    run_op(64'h8000_0000_7FFF_FFFF, 64'h0FFF_0001_0000_0001, 1'b1, 1'b0, 1'b1, dc, bc);
    run_op(64'h0, 64'h0, 1'b0, 1'b0, 1'b1, dc, bc);

    for (int k = 0; k < 6; k++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, 1'b0, 1'b0, dc, bc);
    end

`ifdef CLA_MP_SEQ_SUB_EN
    run_op(64'd5, 64'd7, 1'b0, 1'b1, 1'b0, dc, bc);
    run_op(64'd7, 64'd5, 1'b0, 1'b1, 1'b0, dc, bc);
    run_op(64'd7, 64'd7, 1'b0, 1'b1, 1'b1, dc, bc);
    for (int k = 0; k < 4; k++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, 1'($urandom_range(0, 1)), 1'b0, dc, bc);
    end
`endif

    repeat (5) @(negedge clk);
    check("q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
